// File: rtl/mdll_pkg.sv
// Shared MDLL definitions.
// Coarse delay-line defaults and FSM state type.
package mdll_pkg;

  localparam int DCDL_COARSE_N_STAGE = 16;

  typedef enum logic {
    CC_IDLE,
    CC_HOLD
  } dcdl_coarse_state_t;

endpackage

// File: rtl/mdll_dcdl_coarse_ctrl.sv
// Coarse DCDL sequencer: one-stage steps of a
// registered thermometer, each followed by a settling hold.
module mdll_dcdl_coarse_ctrl
  import mdll_pkg::*;
#(
  parameter int N_STAGE   = DCDL_COARSE_N_STAGE,
  parameter int INIT_CODE = 0,
  parameter int HOLD_CYC  = 4,
  parameter int CW        = $clog2(N_STAGE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_ctl,
  input  logic               inc,
  input  logic               dec,
  input  logic               ovr_en,
  input  logic [CW-1:0]      ovr_code,
  output logic [N_STAGE-1:0] en_ff,
  output logic [CW-1:0]      code,
  output logic               busy,
  output logic               step_ack,
  output logic               sat_hi,
  output logic               sat_lo
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [CW-1:0] MAX_CODE = CW'(N_STAGE - 1);
  localparam logic [CW-1:0] INIT_C   = CW'(INIT_CODE);

  localparam logic [N_STAGE:0] ONE_W = 1;
  localparam logic [N_STAGE-1:0] INIT_THERM =
    N_STAGE'((ONE_W << INIT_CODE) - ONE_W);

  dcdl_coarse_state_t state_q, state_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ovr_tgt;
  logic          req_up, req_dn;
  logic          step_up, step_dn;

  // Out-of-range override targets pin at the top code
  if (N_STAGE == (1 << CW)) begin : g_no_clamp
    assign ovr_tgt = ovr_code;
  end else begin : g_clamp
    assign ovr_tgt = (ovr_code > MAX_CODE) ? MAX_CODE
                                           : ovr_code;
  end

  // Request direction, override has priority over inc/dec
  always_comb begin
    req_up = 1'b0;
    req_dn = 1'b0;
    unique case (1'b1)
      ovr_en: begin
        req_up = (ovr_tgt > code);
        req_dn = (ovr_tgt < code);
      end
      default: begin
        req_up = inc & ~dec;
        req_dn = dec & ~inc;
      end
    endcase
  end

  // Next state, hold counter and step strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    case (state_q)
      CC_IDLE: begin
        if (en_ctl) begin
          step_up = req_up && (code != MAX_CODE);
          step_dn = req_dn && (code != '0);
          if (step_up || step_dn) begin
            state_d = CC_HOLD;
            cnt_d   = HW'(HOLD_CYC - 1);
          end
        end
      end
      CC_HOLD: begin
        if (cnt_q == '0) state_d = CC_IDLE;
        else             cnt_d   = cnt_q - HW'(1);
      end
      default: state_d = CC_IDLE;
    endcase
  end

  // FSM state and settling counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Thermometer, binary code and flags move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_ff    <= INIT_THERM;
      code     <= INIT_C;
      step_ack <= 1'b0;
      sat_hi   <= (INIT_C == MAX_CODE);
      sat_lo   <= (INIT_C == '0);
    end else begin
      step_ack <= step_up | step_dn;
      if (step_up) begin
        en_ff[code] <= 1'b1;
        code        <= code + CW'(1);
        sat_hi      <= (code == MAX_CODE - CW'(1));
        sat_lo      <= 1'b0;
      end else if (step_dn) begin
        en_ff[code - CW'(1)] <= 1'b0;
        code                 <= code - CW'(1);
        sat_lo               <= (code == CW'(1));
        sat_hi               <= 1'b0;
      end
    end
  end

  assign busy = (state_q == CC_HOLD);

endmodule

// File: tb/tb_mdll_dcdl_coarse_ctrl.sv
// Directed bench for the coarse DCDL sequencer.
// N_STAGE=16, INIT_CODE=3, HOLD_CYC=4.
module tb_mdll_dcdl_coarse_ctrl;

  localparam int NS = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en_ctl = 1'b1;
  logic          inc = 1'b0;
  logic          dec = 1'b0;
  logic          ovr_en = 1'b0;
  logic [CW-1:0] ovr_code = '0;
  logic [NS-1:0] en_ff;
  logic [CW-1:0] code;
  logic          busy, step_ack, sat_hi, sat_lo;

  int n_chk = 0;
  int n_err = 0;

  mdll_dcdl_coarse_ctrl #(
    .N_STAGE(NS), .INIT_CODE(3), .HOLD_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .en_ctl(en_ctl),
    .inc(inc), .dec(dec), .ovr_en(ovr_en),
    .ovr_code(ovr_code), .en_ff(en_ff), .code(code),
    .busy(busy), .step_ack(step_ack),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Run n cycles, count acks and busy cycles seen
  task automatic run(input int n,
                     output int acks,
                     output int busys);
    acks = 0;
    busys = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      acks  += int'(step_ack);
      busys += int'(busy);
    end
  endtask

  int a, b, last, nack;
  logic [NS-1:0] prev;

  initial begin
    // reset values
    tick();
    tick();
    chk("rst_en_ff", en_ff, 16'h0007);
    chk("rst_code", code, 3);
    chk("rst_busy", busy, 0);
    chk("rst_ack", step_ack, 0);
    chk("rst_sat_lo", sat_lo, 0);
    chk("rst_sat_hi", sat_hi, 0);
    rst = 1'b0;

    // single inc pulse
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("inc1_en_ff", en_ff, 16'h000F);
    chk("inc1_code", code, 4);
    chk("inc1_ack", step_ack, 1);
    chk("inc1_busy", busy, 1);
    run(7, a, b);
    chk("inc1_ack_cnt", a, 0);
    chk("inc1_busy_cnt", b + 1, 4);

    // held inc for 20 cycles from code 3
    do_reset();
    inc = 1'b1;
    run(20, a, b);
    inc = 1'b0;
    chk("held_acks", a, 4);
    chk("held_code", code, 7);
    chk("held_en_ff", en_ff, 16'h007F);
    tick();
    chk("held_idle", busy, 0);

    // slew to top, then inc at saturation
    ovr_en = 1'b1;
    ovr_code = 4'd15;
    run(50, a, b);
    ovr_en = 1'b0;
    chk("top_code", code, 15);
    chk("top_sat_hi", sat_hi, 1);
    chk("top_en_ff", en_ff, 16'h7FFF);
    inc = 1'b1;
    run(10, a, b);
    inc = 1'b0;
    chk("top_inc_ack", a, 0);
    chk("top_inc_code", code, 15);
    chk("top_inc_busy", b, 0);

    // slew to bottom, then dec at saturation
    ovr_en = 1'b1;
    ovr_code = 4'd0;
    run(80, a, b);
    ovr_en = 1'b0;
    chk("bot_code", code, 0);
    chk("bot_sat_lo", sat_lo, 1);
    chk("bot_sat_hi", sat_hi, 0);
    dec = 1'b1;
    run(10, a, b);
    chk("bot_dec_ack", a, 0);
    chk("bot_dec_code", code, 0);

    // inc and dec together
    inc = 1'b1;
    run(10, a, b);
    inc = 1'b0;
    dec = 1'b0;
    chk("both_ack", a, 0);
    chk("both_code", code, 0);

    // override 2 -> 10: spacing and single-bit steps
    ovr_en = 1'b1;
    ovr_code = 4'd2;
    run(12, a, b);
    chk("ovr2_code", code, 2);
    ovr_code = 4'd10;
    prev = en_ff;
    last = -1;
    nack = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (en_ff != prev)
        chk("ovr_ham", $countones(en_ff ^ prev), 1);
      if (step_ack) begin
        nack++;
        if (last >= 0) chk("ovr_gap", i - last, 5);
        last = i;
      end
      prev = en_ff;
    end
    ovr_en = 1'b0;
    chk("ovr_acks", nack, 8);
    chk("ovr_en_ff", en_ff, 16'h03FF);
    chk("ovr_code", code, 10);

    // reset in second HOLD cycle
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("pre_rst_code", code, 11);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_en_ff", en_ff, 16'h0007);
    chk("mid_rst_code", code, 3);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", step_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("post_rst_code", code, 4);
    chk("post_rst_ack", step_ack, 1);
    run(5, a, b);

    // en_ctl low in IDLE blocks the request
    en_ctl = 1'b0;
    inc = 1'b1;
    run(10, a, b);
    chk("frz_ack", a, 0);
    chk("frz_code", code, 4);

    // en_ctl falling during HOLD
    en_ctl = 1'b1;
    tick();
    en_ctl = 1'b0;
    chk("hold_step_code", code, 5);
    run(8, a, b);
    chk("hold_busy_cnt", b + 1, 4);
    chk("hold_end_busy", busy, 0);
    chk("hold_end_code", code, 5);
    inc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mdll_dcdl_coarse_ctrl.md
# mdll_dcdl_coarse_ctrl

Sequencing controller for the MDLL coarse digitally-controlled delay line (the NAND-based coarse-unit chain). It turns increment/decrement requests from the loop filter, or a static override code, into the per-stage `en_ff` thermometer vector. Each update changes exactly one stage per step and is followed by a programmable settling hold-off, so the coarse path never glitches or skips codes while the MDLL is locked.

## Interface
Parameters:
- `N_STAGE`, 16: number of coarse units in the chain; legal range 2..64.
- `INIT_CODE`, 0: coarse code loaded at reset; range 0..N_STAGE-1.
- `HOLD_CYC`, 4: busy cycles after every step; minimum 1.

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  controller clock (divided reference domain).
- `rst`  in  1  async active-high reset.
- `en_ctl`  in  1  accept new requests when high; when low the code is frozen.
- `inc`  in  1  request one-stage increase (more delay); level, sampled in IDLE.
- `dec`  in  1  request one-stage decrease; level, sampled in IDLE.
- `ovr_en`  in  1  override mode: slew toward `ovr_code`; `inc`/`dec` ignored.
- `ovr_code`  in  CW=$clog2(N_STAGE)  override target code.
- `en_ff`  out  N_STAGE  thermometer to coarse units; `en_ff[i]=1` iff `i < code`.
- `code`  out  CW  current coarse code, binary.
- `busy`  out  1  step in progress or settling.
- `step_ack`  out  1  one-cycle pulse in the cycle `en_ff` changes.
- `sat_hi`  out  1  code == N_STAGE-1.
- `sat_lo`  out  1  code == 0.

## Operation
- `en_ff` comes straight from flops, with no decode logic after the registers. `code` is held in a parallel binary register kept consistent with `en_ff`.
- The FSM has two states, IDLE and HOLD. Reset puts it in IDLE.
- In IDLE with `en_ctl`=1, the step direction is decided in this priority order:
  - `ovr_en`=1 and `ovr_code` > `code`: up.
  - `ovr_en`=1 and `ovr_code` < `code`: down.
  - `ovr_en`=1 and `ovr_code` == `code`: no step.
  - `ovr_en`=0, `inc`=1, `dec`=0: up.
  - `ovr_en`=0, `dec`=1, `inc`=0: down.
  - `inc` and `dec` both high: no step.
- An up step at code N_STAGE-1, or a down step at code 0, is suppressed. The FSM stays in IDLE with no ack.
- A `ovr_code` value ≥ N_STAGE is clamped to N_STAGE-1.
- Step up: set `en_ff[code]`, then code+1. Step down: clear `en_ff[code-1]`, then code-1. Exactly one bit changes per step.
- On a step the FSM enters HOLD and loads the hold counter with HOLD_CYC-1. In HOLD it decrements the counter and returns to IDLE when the counter reaches 0.
- HOLD ignores every input. A request held across HOLD is re-evaluated in the first IDLE cycle, so a held `inc` steps once per HOLD_CYC+1 cycles.
- `en_ctl` falling during HOLD does not abort the hold; only new steps are blocked.
- Changes to `ovr_en` or `ovr_code` take effect at the next IDLE evaluation.

## Timing
- Reset values:
  - `en_ff` = thermometer(INIT_CODE); `code` = INIT_CODE.
  - `busy` = 0; `step_ack` = 0.
  - `sat_hi` and `sat_lo` reflect INIT_CODE.
- Request latency: a request sampled high in IDLE at edge k produces the new `en_ff`/`code`, `step_ack`=1 and `busy`=1 during cycle k+1.
- `busy` stays high for exactly HOLD_CYC cycles (k+1 .. k+HOLD_CYC). The next request can be sampled at edge k+HOLD_CYC+1.
- `busy`, `step_ack`, `sat_hi` and `sat_lo` are registered outputs, with no combinational path from inputs.
- Reset asserted mid-HOLD: all outputs return asynchronously to their reset values. Operation resumes in IDLE at the first edge after `rst` deasserts.
- Override slew from code a to code b takes |a-b|·(HOLD_CYC+1) cycles, with |a-b| `step_ack` pulses.

## Structure
- `mdll_pkg` adds:
  - `DCDL_COARSE_N_STAGE` as the default for `N_STAGE`.
  - `typedef enum logic {CC_IDLE, CC_HOLD} dcdl_coarse_state_t`.
- Single module, with no sub-module. Thermometer update and binary counter are kept in the same always_ff block.

## Test plan
- Reset with INIT_CODE=3, N_STAGE=16 → `en_ff`=16'h0007, `code`=3, `busy`=0, `sat_lo`=0.
- Pulse `inc` for one cycle from code 3, HOLD_CYC=4 → `en_ff`=16'h000F one cycle later, `step_ack` for 1 cycle, `busy` for exactly 4 cycles. Holding `inc` for 20 cycles from code 3 → code 7.
- `inc` held at code 15 → no change, `sat_hi`=1, no `step_ack`. `dec` at code 0 → no change, `sat_lo`=1. `inc`&`dec` together → no step.
- `ovr_en`=1, `ovr_code`=10 from code 2 → 8 single-bit steps, spaced 5 cycles apart. Every `en_ff` transition has Hamming distance 1. The slew ends at `en_ff`=16'h03FF.
- `rst` asserted in the 2nd HOLD cycle → immediate return to INIT_CODE, `busy`=0. After release, `inc` is accepted on the first edge.
- `en_ctl` dropped while `inc` is high in IDLE → no step. `en_ctl` dropped during HOLD → hold completes with the code unchanged afterwards.
